// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// branch_predictor_pkg : shared encodings for the predictor and next-PC logic
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

  // 2-bit saturating counter states; the prediction is bit 1
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // next-PC source select, shared with the next-PC mux
  localparam logic [1:0] EM_OTHER  = 2'd0;
  localparam logic [1:0] EM_JALR   = 2'd1;
  localparam logic [1:0] EM_BRANCH = 2'd2;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
// ============================================================================
// sat_counter2 : next-state function of a 2-bit saturating counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = state + 2'd1;
    end else begin
      if (state != SNT) next_state = state - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor : PC-indexed 2-bit counter table, resolution control and
//                    branch / mispredict performance counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] current_pc,
  output logic        c_guess,
  input  logic        em_valid,
  input  logic        em_is_branch,
  input  logic        em_is_jalr,
  input  logic [31:0] em_pc,
  input  logic        em_guess,
  input  logic        em_taken,
  output logic        hit,
  output logic [1:0]  em_type,
  output logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  logic [1:0]       pht [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       upd_state;
  logic             jalr_ev;
  logic             br_ev;
  logic             unused_pc_bits;

  assign rd_idx = current_pc[IDX_W+1:2];
  assign wr_idx = em_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{current_pc[31:IDX_W+2], current_pc[1:0],
                            em_pc[31:IDX_W+2], em_pc[1:0]};

  // Plain array read: a same-cycle training write is not bypassed
  assign c_guess = pht[rd_idx][1];

  // JALR wins when the decode flags both
  assign jalr_ev = em_valid & em_is_jalr;
  assign br_ev   = em_valid & em_is_branch & ~em_is_jalr;

  always_comb begin
    em_type = EM_OTHER;
    if (jalr_ev)    em_type = EM_JALR;
    else if (br_ev) em_type = EM_BRANCH;
  end

  assign hit   = br_ev ? ~(em_guess ^ em_taken) : 1'b1;
  assign flush = jalr_ev | (br_ev & ~hit);

  sat_counter2 u_sat (
    .state      (pht[wr_idx]),
    .taken      (em_taken),
    .next_state (upd_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= WNT;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (br_ev) begin
      pht[wr_idx] <= upd_state;
      branch_cnt  <= branch_cnt + 32'd1;
      if (!hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire
